// File: rtl/pipeline_flow_ctl_if.sv
// Handshake bundle between the pipeline datapath and its flow controller.
// The master side drives the hazard/stall requests, the slave side (the
// controller) returns per-stage valid/enable/bubble information and counters.
interface pipeline_flow_ctl_if #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 32
);
    logic              fetch_valid;
    logic              want_stall;
    logic              load_use_hazard;
    logic              mem_wait;
    logic              mc_start;
    logic              mc_done;
    logic              redirect;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_enable;
    logic [STAGES-1:0] bubble_mask;
    logic              pc_write_enable;
    logic              no_stall;
    logic              inject_bubble;
    logic              redirect_accept;
    logic              mc_busy;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  bubble_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output fetch_valid, want_stall, load_use_hazard, mem_wait,
               mc_start, mc_done, redirect,
        input  stage_valid, stage_enable, bubble_mask, pc_write_enable,
               no_stall, inject_bubble, redirect_accept, mc_busy,
               stall_cycles, bubble_count, flush_count
    );

    modport slave (
        input  fetch_valid, want_stall, load_use_hazard, mem_wait,
               mc_start, mc_done, redirect,
        output stage_valid, stage_enable, bubble_mask, pc_write_enable,
               no_stall, inject_bubble, redirect_accept, mc_busy,
               stall_cycles, bubble_count, flush_count
    );
endinterface

// File: rtl/pipeline_flow_ctl.sv
// Stall/flush/valid controller for an N-stage pipeline.
// Merges the stall sources into a single "stall horizon" (highest stalled
// stage), derives per-stage enables and the bubble position from it, tracks
// per-stage valid bits, squashes the younger stages on an accepted redirect
// and sequences multi-cycle EX operations with a small IDLE/BUSY FSM.
// Optional: define PIPELINE_PERF_COUNTERS_EN to build the saturating
// stall/bubble/flush counters; otherwise those outputs are tied to zero.
module pipeline_flow_ctl #(
    parameter int STAGES    = 5,
    parameter int EX_STAGE  = 2,
    parameter int MEM_STAGE = 3,
    parameter int CNT_W     = 32
) (
    input  logic               clock,
    input  logic               reset,
    pipeline_flow_ctl_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mcState_t;

    mcState_t          r_mcState;
    mcState_t          w_mcNext;
    logic              w_mcHold;
    logic [STAGES-1:0] r_stageValid;
    logic [STAGES-1:0] w_stageEnable;
    logic [STAGES-1:0] w_bubbleMask;
    logic              w_redirectAccept;
    int                w_horizon;

    // Multi-cycle unit state register; reset abandons any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mcState <= IDLE;
        end else begin
            r_mcState <= w_mcNext;
        end
    end

    // Multi-cycle next state and EX hold; hold starts in the accepting cycle and drops on mc_done.
    always_comb begin
        w_mcNext = r_mcState;
        w_mcHold = 1'b0;
        case (r_mcState)
            IDLE: begin
                if (bus.mc_start && r_stageValid[EX_STAGE]) begin
                    w_mcNext = BUSY;
                    w_mcHold = 1'b1;
                end
            end
            BUSY: begin
                if (bus.mc_done) begin
                    w_mcNext = IDLE;
                end else begin
                    w_mcHold = 1'b1;
                end
            end
            default: begin
                w_mcNext = IDLE;
            end
        endcase
    end

    // Stall horizon: later (higher-index) sources override earlier ones, giving the maximum.
    always_comb begin
        w_horizon = -1;
        if (bus.load_use_hazard) w_horizon = EX_STAGE - 1;
        if (w_mcHold)            w_horizon = EX_STAGE;
        if (bus.mem_wait)        w_horizon = MEM_STAGE;
        if (bus.want_stall)      w_horizon = STAGES - 1;
    end

    // Stages beyond the horizon advance; the first of them receives a bubble.
    always_comb begin
        w_stageEnable = '0;
        w_bubbleMask  = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_stageEnable[i] = (i > w_horizon);
            w_bubbleMask[i]  = (w_horizon >= 0) && (w_horizon < STAGES - 1) &&
                               (i == w_horizon + 1);
        end
    end

    assign w_redirectAccept = bus.redirect & r_stageValid[EX_STAGE] & w_stageEnable[EX_STAGE];

    // Valid bits shift forward through enabled stages; an accepted redirect kills fetch..EX.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stageValid <= '0;
        end else begin
            if (w_stageEnable[0]) begin
                r_stageValid[0] <= w_redirectAccept ? 1'b0 : bus.fetch_valid;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_stageEnable[i]) begin
                    r_stageValid[i] <= (w_redirectAccept && (i <= EX_STAGE)) ? 1'b0 :
                                       (r_stageValid[i-1] & w_stageEnable[i-1]);
                end
            end
        end
    end

    assign bus.stage_valid     = r_stageValid;
    assign bus.stage_enable    = w_stageEnable;
    assign bus.bubble_mask     = w_bubbleMask;
    assign bus.pc_write_enable = w_stageEnable[0];
    assign bus.no_stall        = (w_horizon == -1);
    assign bus.inject_bubble   = |w_bubbleMask;
    assign bus.redirect_accept = w_redirectAccept;
    assign bus.mc_busy         = (r_mcState == BUSY);

`ifdef PIPELINE_PERF_COUNTERS_EN
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_bubbleCount;
    logic [CNT_W-1:0] r_flushCount;

    // Saturating event counters for stalled cycles, injected bubbles and accepted flushes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stallCycles <= '0;
            r_bubbleCount <= '0;
            r_flushCount  <= '0;
        end else begin
            if ((w_horizon >= 0) && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + CNT_W'(1);
            end
            if ((|w_bubbleMask) && (r_bubbleCount != '1)) begin
                r_bubbleCount <= r_bubbleCount + CNT_W'(1);
            end
            if (w_redirectAccept && (r_flushCount != '1)) begin
                r_flushCount <= r_flushCount + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles = r_stallCycles;
    assign bus.bubble_count = r_bubbleCount;
    assign bus.flush_count  = r_flushCount;
`else
    assign bus.stall_cycles = '0;
    assign bus.bubble_count = '0;
    assign bus.flush_count  = '0;
`endif

endmodule
